// File: rtl/display_pkg.sv
// Shared types and constants for the LED display back-end.
package display_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_N = 4;
  localparam int unsigned DIGIT_W = 2;

  typedef logic [SEG_W-1:0] seg_t;

  localparam logic [DIGIT_W-1:0] DIGIT_MIN_U = 2'd0;
  localparam logic [DIGIT_W-1:0] DIGIT_MIN_T = 2'd1;
  localparam logic [DIGIT_W-1:0] DIGIT_HR_U  = 2'd2;
  localparam logic [DIGIT_W-1:0] DIGIT_HR_T  = 2'd3;

  localparam seg_t               SEG_ZERO   = 7'b1111110;
  localparam seg_t               SEG_OFF    = 7'h7F;
  localparam logic [DIGIT_N-1:0] ANODES_OFF = 4'b1111;

  // One frame of display content, latched as a unit so a frame never tears.
  typedef struct packed {
    seg_t hr_t;
    seg_t hr_u;
    seg_t min_t;
    seg_t min_u;
    logic pm;
  } frame_t;

  // Active-low one-hot anode select for a digit index.
  function automatic logic [DIGIT_N-1:0] anode_sel(input logic [DIGIT_W-1:0] d);
    return ~(DIGIT_N'(1) << d);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler: counts cycles per digit slot and flags the dead-time window.
module scan_prescaler #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned DEAD     = 16
) (
  input  logic CLOCK,
  input  logic resetn,
  input  logic test_mode,
  output logic slot_tick_c,
  output logic in_dead_c
);

  localparam int unsigned     PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;

  assign slot_tick_c = test_mode || (pcnt == LAST);

  // Bypass holds the counter at zero so normal scanning restarts cleanly.
  always_comb begin
    pcnt_nxt = pcnt + PW'(1);
    if (test_mode || slot_tick_c) pcnt_nxt = '0;
  end

  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) pcnt <= '0;
    else         pcnt <= pcnt_nxt;
  end

  if (DEAD == 0) begin : g_no_dead
    assign in_dead_c = 1'b0;
  end else begin : g_dead
    assign in_dead_c = !test_mode && (pcnt < PW'(DEAD));
  end

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed 4-digit common-anode LED driver with frame snapshot and blinking colon.
module led_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned DEAD         = 16,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic                CLOCK,
  input  logic                resetn,
  input  logic [13:0]         hr_wire,
  input  logic [13:0]         min_wire,
  input  logic                am_pm_wire,
  input  logic                blank_lead_zero,
  input  logic                TEST_MODE,
  output seg_t                seg_out,
  output logic                dp_out,
  output logic [DIGIT_N-1:0]  an_out,
  output logic                frame_tick
);

  localparam int unsigned   BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic               slot_tick_c;
  logic               in_dead_c;
  logic               snap_c;
  logic [DIGIT_W-1:0] digit;
  frame_t             snap;
  logic [BW-1:0]      blink_cnt;
  logic               colon;

  seg_t               sel_c;
  seg_t               seg_nxt;
  logic               dp_nxt;
  logic [DIGIT_N-1:0] an_nxt;

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .DEAD     (DEAD)
  ) u_prescaler (
    .CLOCK       (CLOCK),
    .resetn      (resetn),
    .test_mode   (TEST_MODE),
    .slot_tick_c (slot_tick_c),
    .in_dead_c   (in_dead_c)
  );

  assign snap_c = slot_tick_c && (digit == DIGIT_HR_T);

  // Digit scan, frame snapshot and colon blink state.
  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) begin
      digit     <= '0;
      snap      <= '0;
      blink_cnt <= '0;
      colon     <= 1'b0;
    end else begin
      if (slot_tick_c) digit <= digit + DIGIT_W'(1);
      if (snap_c) begin
        snap <= '{hr_t:  hr_wire[13:7],  hr_u:  hr_wire[6:0],
                  min_t: min_wire[13:7], min_u: min_wire[6:0],
                  pm:    am_pm_wire};
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          colon     <= ~colon;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // Output selection from the pre-update state; registered below.
  always_comb begin
    sel_c  = snap.min_u;
    dp_nxt = 1'b1;
    an_nxt = ANODES_OFF;
    case (digit)
      DIGIT_MIN_U: begin sel_c = snap.min_u; dp_nxt = ~snap.pm; end
      DIGIT_MIN_T: sel_c = snap.min_t;
      DIGIT_HR_U:  begin sel_c = snap.hr_u; dp_nxt = ~colon; end
      default:     sel_c = snap.hr_t;
    endcase
    seg_nxt = ~sel_c;
    if ((digit == DIGIT_HR_T) && blank_lead_zero && (snap.hr_t == SEG_ZERO)) seg_nxt = SEG_OFF;
    if (!in_dead_c) an_nxt = anode_sel(digit);
  end

  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) begin
      an_out     <= ANODES_OFF;
      seg_out    <= SEG_OFF;
      dp_out     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an_out     <= an_nxt;
      seg_out    <= seg_nxt;
      dp_out     <= dp_nxt;
      frame_tick <= snap_c;
    end
  end

endmodule
